// File: rtl/sysid_regbank.sv
// System ID / build-info register bank with scratch words and an optional 64-bit uptime counter.
// Build macro SYSID_UPTIME_EN adds the uptime counter, its HI shadow and the CTRL register.
module sysid_regbank #(
    parameter logic [31:0] SYS_ID      = 32'h0100_0001,
    parameter logic [31:0] BUILD_TS    = 32'h5820_ADA2,
    parameter int          ADDR_W      = 4,
    parameter int          NUM_SCRATCH = 4,
    parameter int          RD_LAT      = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);
    // Handshake: no waitrequest; every cycle with read=1 is one accepted read whose
    // response (readdatavalid=1 for exactly one cycle) follows RD_LAT cycles later,
    // in issue order; writes complete at the accepting edge; readdata is 0 when not valid.

    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif
    localparam logic [31:0] CAPS = {23'd0, UPTIME_PRESENT, 2'd0, 2'(RD_LAT), 4'(NUM_SCRATCH)};

    logic [31:0]       rd_mux;
    logic [31:0]       scratch [SCR_N];
    logic [RD_LAT-1:0] vld_pipe;
    logic [31:0]       dat_pipe [RD_LAT];

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic        freeze;
    logic        ctrl_wr;

    assign ctrl_wr = write && (address == ADDR_W'(5));

    // CLEAR wins over increment; a FREEZE written now only gates the following edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime           <= '0;
            uptime_hi_shadow <= '0;
            freeze           <= 1'b0;
        end else begin
            if (ctrl_wr && writedata[1]) begin
                uptime <= '0;
            end else if (!freeze) begin
                uptime <= uptime + 64'd1;
            end
            if (ctrl_wr) begin
                freeze <= writedata[0];
            end
            if (read && (address == ADDR_W'(3))) begin
                uptime_hi_shadow <= uptime[63:32];
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SCR_N; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (write && (address == ADDR_W'(8 + i))) begin
                    scratch[i] <= writedata;
                end
            end
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write to the read word returns the old value.
    always_comb begin
        rd_mux = 32'h0;
        if (address == ADDR_W'(0)) rd_mux = SYS_ID;
        if (address == ADDR_W'(1)) rd_mux = BUILD_TS;
        if (address == ADDR_W'(2)) rd_mux = CAPS;
`ifdef SYSID_UPTIME_EN
        if (address == ADDR_W'(3)) rd_mux = uptime[31:0];
        if (address == ADDR_W'(4)) rd_mux = uptime_hi_shadow;
        if (address == ADDR_W'(5)) rd_mux = {31'd0, freeze};
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(8 + i)) rd_mux = scratch[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= read;
            dat_pipe[0] <= read ? rd_mux : 32'h0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign readdatavalid = vld_pipe[RD_LAT-1];
    assign readdata      = dat_pipe[RD_LAT-1];

endmodule

// File: tb/tb_sysid_regbank.sv
// Scoreboard bench for sysid_regbank: a default instance (RD_LAT=1) and an RD_LAT=3 instance.
// Uptime checks are compiled only when SYSID_UPTIME_EN is defined.
module tb_sysid_regbank;
    logic        clock = 1'b0;
    logic        reset_n, rst3_n;
    logic [3:0]  address, address3;
    logic        read, write, read3, write3;
    logic [31:0] writedata, writedata3, readdata, readdata3;
    logic        readdatavalid, readdatavalid3;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int post_flush_valid = 0;
    bit flush_watch = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp3_q[$];
    int cyc_q[$];
    int cyc3_q[$];

`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] UP_BIT = 32'h0000_0100;
`else
    localparam logic [31:0] UP_BIT = 32'h0000_0000;
`endif
    localparam logic [31:0] SYS_ID   = 32'h0100_0001;
    localparam logic [31:0] BUILD_TS = 32'h5820_ADA2;
    localparam logic [31:0] CAPS1    = 32'h0000_0014 | UP_BIT;
    localparam logic [31:0] CAPS3    = 32'h0000_0034 | UP_BIT;

    sysid_regbank dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    sysid_regbank #(.RD_LAT(3)) dut3 (
        .clock(clock), .reset_n(rst3_n), .address(address3), .read(read3), .write(write3),
        .writedata(writedata3), .readdata(readdata3), .readdatavalid(readdatavalid3)
    );

    // clock / reset / cycle count
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required under 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // monitors
    always @(negedge clock) begin
        if (readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_valid: got data %h at cycle %0d, expected no response", readdata, cyc);
            end else begin
                check("dut1_rdata", readdata, exp_q.pop_front());
                check("dut1_latency", 32'(cyc), 32'(cyc_q.pop_front()));
            end
        end else begin
            check("dut1_idle_zero", readdata, 32'h0);
        end
    end

    always @(negedge clock) begin
        if (readdatavalid3 === 1'b1) begin
            if (flush_watch) post_flush_valid++;
            if (exp3_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut3_unexpected_valid: got data %h at cycle %0d, expected no response", readdata3, cyc);
            end else begin
                check("dut3_rdata", readdata3, exp3_q.pop_front());
                check("dut3_latency", 32'(cyc), 32'(cyc3_q.pop_front()));
            end
        end else begin
            check("dut3_idle_zero", readdata3, 32'h0);
        end
    end

    // driver tasks: inputs change #1 after the rising edge, the next edge accepts them
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle1(input int n);
        read = 1'b0; write = 1'b0; writedata = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd1(input logic [3:0] a, input logic [31:0] e);
        read = 1'b1; write = 1'b0; address = a; writedata = '0;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
        step();
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] d);
        read = 1'b0; write = 1'b1; address = a; writedata = d;
        step();
    endtask

    task automatic rw1(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
        read = 1'b1; write = 1'b1; address = a; writedata = d;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
        step();
    endtask

    task automatic idle3(input int n);
        read3 = 1'b0; write3 = 1'b0; writedata3 = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd3(input logic [3:0] a, input logic [31:0] e);
        read3 = 1'b1; write3 = 1'b0; address3 = a; writedata3 = '0;
        exp3_q.push_back(e);
        cyc3_q.push_back(cyc + 3);
        step();
    endtask

    task automatic wr3(input logic [3:0] a, input logic [31:0] d);
        read3 = 1'b0; write3 = 1'b1; address3 = a; writedata3 = d;
        step();
    endtask

    initial begin
        logic [31:0] scr_val [4];
        logic [3:0]  unmapped [6];
        int          wait_cnt;
        scr_val  = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
        unmapped = '{4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15};

        reset_n = 1'b0; rst3_n = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        read3 = 1'b0; write3 = 1'b0; address3 = '0; writedata3 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", {31'd0, readdatavalid}, 32'h0);
        check("reset_rdata", readdata, 32'h0);
        reset_n = 1'b1; rst3_n = 1'b1;

        // identity words back-to-back from the first edge after reset
        rd1(4'd0, SYS_ID);
        rd1(4'd1, BUILD_TS);
        rd1(4'd2, CAPS1);
        idle1(2);

        // scratch and unmapped
        wr1(4'd9, 32'hA5A5_5A5A);
        rd1(4'd9, 32'hA5A5_5A5A);
        rd1(4'd13, 32'h0);
        idle1(1);

        // writes to read-only words are ignored
        wr1(4'd0, 32'hFFFF_FFFF);
        wr1(4'd1, 32'h0);
        wr1(4'd2, 32'hFFFF_FFFF);
        rd1(4'd0, SYS_ID);
        rd1(4'd1, BUILD_TS);
        rd1(4'd2, CAPS1);
        idle1(1);

        for (int i = 0; i < 4; i++) wr1(4'(8 + i), scr_val[i]);
        for (int i = 0; i < 4; i++) rd1(4'(8 + i), scr_val[i]);
        for (int i = 0; i < 6; i++) wr1(unmapped[i], 32'h5555_AAAA);
        for (int i = 0; i < 6; i++) rd1(unmapped[i], 32'h0);
        for (int i = 0; i < 4; i++) rd1(4'(8 + i), scr_val[i]);

        // same-cycle read and write of one word: old value now, new value next
        rw1(4'd10, 32'h1234_5678, 32'hDEAD_0002);
        rd1(4'd10, 32'h1234_5678);
        idle1(2);

`ifdef SYSID_UPTIME_EN
        wr1(4'd5, 32'h3);          // clear and freeze: counter held at 0
        idle1(2);
        rd1(4'd3, 32'h0);
        wr1(4'd5, 32'h0);          // unfreeze; this edge still sees the old freeze
        idle1(4);
        wr1(4'd5, 32'h1);          // this edge still increments, then frozen at 5
        idle1(2);
        rd1(4'd3, 32'h5);
        idle1(9);
        rd1(4'd3, 32'h5);
        rd1(4'd5, 32'h1);
        wr1(4'd5, 32'h2);          // clear, unfreeze
        rd1(4'd3, 32'h0);
        rd1(4'd3, 32'h1);
        rd1(4'd5, 32'h0);

        // carry coherence
        wr1(4'd5, 32'h1);
        idle1(1);
        force dut1.uptime = 64'h0000_0000_FFFF_FFFE;
        idle1(1);
        release dut1.uptime;
        rd1(4'd3, 32'hFFFF_FFFE);
        idle1(4);
        rd1(4'd4, 32'h0);
        wr1(4'd5, 32'h0);
        idle1(2);
        rd1(4'd3, 32'h0);
        idle1(4);
        rd1(4'd4, 32'h1);
        idle1(3);
        rd1(4'd4, 32'h1);
`else
        rd1(4'd3, 32'h0);
        rd1(4'd4, 32'h0);
        rd1(4'd5, 32'h0);
        wr1(4'd5, 32'h3);
        wr1(4'd3, 32'hFFFF_FFFF);
        rd1(4'd5, 32'h0);
        rd1(4'd3, 32'h0);
`endif
        idle1(2);

        // RD_LAT=3 instance: latency, ordering, then flush by reset
        wr3(4'd8, 32'hCAFE_0008);
        rd3(4'd0, SYS_ID);
        rd3(4'd1, BUILD_TS);
        rd3(4'd2, CAPS3);
        rd3(4'd8, 32'hCAFE_0008);
        idle3(6);
        rd3(4'd8, 32'hCAFE_0008);
        rd3(4'd2, CAPS3);
        rd3(4'd1, BUILD_TS);
        rd3(4'd0, SYS_ID);
        read3 = 1'b0;
        exp3_q.delete();
        cyc3_q.delete();
        flush_watch = 1'b1;
        rst3_n = 1'b0;
        idle3(2);
        rst3_n = 1'b1;
        idle3(8);
        flush_watch = 1'b0;
        check("dut3_flush_no_response", 32'(post_flush_valid), 32'h0);
        rd3(4'd8, 32'h0);
        idle3(1);

        // scratch reset on the default instance
        reset_n = 1'b0;
        idle1(2);
        check("rereset_valid", {31'd0, readdatavalid}, 32'h0);
        reset_n = 1'b1;
        rd1(4'd9, 32'h0);
        rd1(4'd10, 32'h0);
        idle1(1);

        wait_cnt = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0) && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        check("pending_dut1", 32'(exp_q.size()), 32'h0);
        check("pending_dut3", 32'(exp3_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysid_regbank.md
SYSID_REGBANK -- requirements
Module: sysid_regbank

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- SYS_ID, 32'h0100_0001, read-only system identifier word.
- BUILD_TS, 32'h5820_ADA2, read-only build timestamp word.
- ADDR_W, 4, word-address width; map spans 2**ADDR_W words.
- NUM_SCRATCH, 4, scratch registers (0..8), placed at word 8 upward.
- RD_LAT, 1, read latency in cycles (1..3).
REQ-002 Ports (one per line: name, direction, width, meaning):
- clock, in, 1, sole clock; all logic rising-edge.
- reset_n, in, 1, asynchronous active-low reset.
- address, in, ADDR_W, word address.
- read, in, 1, read strobe, one access per asserted cycle.
- write, in, 1, write strobe.
- writedata, in, 32, write data.
- readdata, out, 32, read data, valid only when readdatavalid=1.
- readdatavalid, out, 1, read-response qualifier.

Function
REQ-003 The block SHALL never stall: it has no waitrequest, and it accepts a read or write every cycle.
REQ-004 Word map:
- 0: SYS_ID (RO).
- 1: BUILD_TS (RO).
- 2: CAPS (RO). Bits [3:0] hold NUM_SCRATCH, bits [5:4] hold RD_LAT, bit 8 holds the uptime-present flag, all other bits are 0.
- 3: UPTIME_LO (RO).
- 4: UPTIME_HI_SHADOW (RO).
- 5: CTRL (RW). Bit 0 is FREEZE. Bit 1 is CLEAR, which is write-1-pulse and always reads 0.
- 8..8+NUM_SCRATCH-1: SCRATCH (RW, 32-bit).
REQ-005 Reads of unmapped words SHALL return 32'h0. Writes to RO or unmapped words SHALL be ignored.
REQ-006 A read accepted in cycle N SHALL assert readdatavalid with the data exactly RD_LAT cycles later, for one cycle per accepted read. Back-to-back reads SHALL produce back-to-back responses in order.
REQ-007 readdata SHALL be 0 whenever readdatavalid=0.
REQ-008 If read and write hit the same word in the same cycle, the read SHALL return the pre-write value, and the write SHALL take effect at the next clock edge.
REQ-009 The uptime counter SHALL be 64 bits wide. It SHALL increment by 1 every cycle while FREEZE=0 and hold while FREEZE=1.
REQ-010 The uptime counter SHALL wrap from 2**64-1 to 0 with no flag.
REQ-011 A read of UPTIME_LO SHALL return counter[31:0] as sampled in the accept cycle. In that same cycle the block SHALL capture counter[63:32] into the HI shadow.
REQ-012 A read of word 4 SHALL return the shadow and SHALL NOT update it. This makes LO-then-HI coherent across a carry.
REQ-013 Writing CTRL with bit1=1 SHALL zero the counter at that clock edge, and CLEAR SHALL take precedence over increment.
REQ-014 The FREEZE bit in the same write SHALL apply from the next cycle.
REQ-015 A read of UPTIME_LO in the same cycle as a CLEAR write SHALL return the pre-clear value.

Reset
REQ-016 reset_n=0 SHALL asynchronously force the following to 0: readdata, readdatavalid, the read pipeline, the counter, the shadow, CTRL and all SCRATCH.
REQ-017 Reads in flight at reset assertion SHALL be discarded, with no response after reset release.
REQ-018 The first access SHALL be accepted in the first clock edge with reset_n=1.

Configuration
REQ-019 Macro SYSID_UPTIME_EN:
- Defined: the counter, the shadow and CTRL are implemented per REQ-009..REQ-015, and CAPS bit 8 reads 1.
- Undefined: the counter, shadow and CTRL logic are absent. Words 3, 4 and 5 read 0, writes to them are ignored, and CAPS bit 8 reads 0.
- All other behaviour is identical in both builds.

Verification
REQ-020 Read after reset:
- Stimulus: after reset, read words 0, 1 and 2 back-to-back with defaults.
- Required response: readdatavalid high on cycles 1, 2 and 3 with 32'h0100_0001, 32'h5820_ADA2 and 32'h0000_0114.
REQ-021 Scratch and unmapped access:
- Stimulus: write 32'hA5A5_5A5A to word 9, then read words 9 and 13.
- Required response: 32'hA5A5_5A5A, then 32'h0.
- Stimulus: write word 0.
- Required response: a re-read of word 0 still returns 32'h0100_0001.
REQ-022 Uptime carry coherence:
- Stimulus: force the counter to 64'h0000_0000_FFFF_FFFE and read LO, then HI, 5 cycles apart.
- Required response: LO 32'hFFFF_FFFE and HI 32'h0.
- Stimulus: repeat the LO/HI read after the carry.
- Required response: HI 32'h1.
REQ-023 Freeze and clear:
- Stimulus: write CTRL=32'h1, then read LO twice, 10 cycles apart.
- Required response: identical values.
- Stimulus: write CTRL=32'h2.
- Required response: LO read 1 cycle later returns 32'h0 (FREEZE now 0).
REQ-024 Read latency and reset flush:
- Stimulus: RD_LAT=3 build, issue 4 consecutive reads.
- Required response: responses in cycles 3..6, in order.
- Stimulus: assert reset_n=0 one cycle after the last read.
- Required response: no readdatavalid pulse afterwards.
REQ-025 Build with SYSID_UPTIME_EN undefined:
- Stimulus: read words 2, 3 and 5 after reset.
- Required response: 32'h0000_0014, 32'h0 and 32'h0.
